// File: rtl/agg_pkg.sv
// Shared constants and types for the SGBM aggregate-cost path.
package agg_pkg;

    localparam int unsigned FRAME_WIDTH  = 400;
    localparam int unsigned FRAME_HEIGHT = 200;
    localparam int unsigned DISP_RANGE   = 108;
    localparam int unsigned PIXEL_WIDTH  = 8;
    localparam int unsigned COST_W       = DISP_RANGE * PIXEL_WIDTH;
    localparam int unsigned IDX_W        = 10;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StCheck,
        StDone
    } sched_state_e;

endpackage

// File: rtl/agg_stream_scheduler_if.sv
// Handshake and delay_buffer control bundle between the scheduler and its environment.
interface agg_stream_scheduler_if;
    import agg_pkg::*;

    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             buf_valid;
    logic             buf_en;
    logic             buf_flush;
    logic [IDX_W-1:0] buf_row;
    logic [IDX_W-1:0] buf_col;
    logic             busy;
    logic             frame_done;
    logic             cnt_err;

    modport master (
        input  start, abort, in_valid, out_ready, buf_valid,
        output in_ready, buf_en, buf_flush, buf_row, buf_col, busy, frame_done, cnt_err
    );

    modport slave (
        output start, abort, in_valid, out_ready, buf_valid,
        input  in_ready, buf_en, buf_flush, buf_row, buf_col, busy, frame_done, cnt_err
    );

endinterface

// File: rtl/raster_counter.sv
// Row/column raster position counter; saturates on the last pixel of the frame.
module raster_counter #(
    parameter int unsigned WIDTH  = 400,
    parameter int unsigned HEIGHT = 200,
    parameter int unsigned IDX_W  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] ColMax = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] RowMax = IDX_W'(HEIGHT - 1);

    logic [IDX_W-1:0] row_q, col_q;

    assign last_o = (row_q == RowMax) && (col_q == ColMax);
    assign row_o  = row_q;
    assign col_o  = col_q;

    // The last pixel does not advance, so indices stay on it until the next clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance_i && !last_o) begin
            if (col_q == ColMax) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/agg_stream_scheduler.sv
// Frame sequencer for delay_buffer: raster-indexes accepted vectors, flushes the
// buffer pipeline after the last pixel, then checks the output count.
module agg_stream_scheduler
    import agg_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = agg_pkg::FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT = agg_pkg::FRAME_HEIGHT,
    parameter int unsigned PIPE_DELAY   = 4,
    parameter int unsigned CNT_W        = 20
) (
    input logic                    clk,
    input logic                    rst,
    agg_stream_scheduler_if.master bus
);

    if (longint'(FRAME_WIDTH) * longint'(FRAME_HEIGHT) >= (longint'(1) << CNT_W)) begin : g_cnt_chk
        $error("CNT_W too narrow for FRAME_WIDTH*FRAME_HEIGHT");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 63) begin : g_pd_chk
        $error("PIPE_DELAY must be in 1..63");
    end
    if (FRAME_WIDTH > (1 << IDX_W) || FRAME_HEIGHT > (1 << IDX_W)) begin : g_idx_chk
        $error("frame dimensions exceed index width");
    end

    localparam logic [CNT_W-1:0] FramePixels = CNT_W'(FRAME_WIDTH * FRAME_HEIGHT);
    localparam logic [5:0]       PipeDelay   = 6'(PIPE_DELAY);

    sched_state_e     state_q;
    logic [CNT_W-1:0] in_cnt_q, out_cnt_q;
    logic [5:0]       flush_cnt_q;
    logic             busy_q, frame_done_q, cnt_err_q;

    logic             run_st, flush_st, frame_start, accept, flush_en, out_count_en;
    logic             last_pixel;
    logic [IDX_W-1:0] row, col;

    assign run_st      = (state_q == StRun);
    assign flush_st    = (state_q == StFlush);
    assign frame_start = (state_q == StIdle) && bus.start && !bus.abort;

    // Abort masks the handshake in the same cycle it is seen.
    assign accept   = run_st && bus.out_ready && bus.in_valid && !bus.abort;
    assign flush_en = flush_st && bus.out_ready && !bus.abort;

    assign out_count_en = (run_st || flush_st) && bus.buf_valid && bus.out_ready &&
                          (flush_cnt_q < PipeDelay);

    assign bus.in_ready   = run_st && bus.out_ready && !bus.abort;
    assign bus.buf_en     = accept || flush_en;
    assign bus.buf_flush  = flush_en;
    assign bus.buf_row    = row;
    assign bus.buf_col    = col;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cnt_err    = cnt_err_q;

    raster_counter #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT),
        .IDX_W  (IDX_W)
    ) u_raster (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (frame_start),
        .advance_i (accept),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (out_count_en) out_cnt_q <= out_cnt_q + 1'b1;

            if (bus.abort && state_q != StIdle) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (frame_start) begin
                            state_q     <= StRun;
                            busy_q      <= 1'b1;
                            in_cnt_q    <= '0;
                            out_cnt_q   <= '0;
                            flush_cnt_q <= '0;
                            cnt_err_q   <= 1'b0;
                        end else if (bus.buf_valid) begin
                            cnt_err_q <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (accept) begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                            if (last_pixel) state_q <= StFlush;
                        end
                    end
                    StFlush: begin
                        if (flush_en) begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                            if (flush_cnt_q == PipeDelay - 6'd1) state_q <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (out_cnt_q != FramePixels || in_cnt_q != FramePixels) begin
                            cnt_err_q <= 1'b1;
                        end
                        frame_done_q <= 1'b1;
                        state_q      <= StDone;
                    end
                    StDone: begin
                        if (bus.buf_valid) cnt_err_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agg_stream_scheduler.sv
// Self-checking bench for agg_stream_scheduler with a small delay_buffer model.
module tb_agg_stream_scheduler;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned PD   = 2;
    localparam int          NPIX = W * H;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_CHECK = 3;
    localparam int P_DONE  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    agg_stream_scheduler_if bus ();

    agg_stream_scheduler #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .PIPE_DELAY   (PD),
        .CNT_W        (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // delay_buffer model: a real vector re-emerges on the PD-th enable after its own
    logic [PD-1:0] pipe_q;
    logic          clear_pipe, drop_req, drop_done, stray, real_out;
    assign real_out      = bus.buf_en & pipe_q[PD-1];
    assign bus.buf_valid = (real_out & ~(drop_req & ~drop_done)) | stray;

    always @(posedge clk) begin
        if (clear_pipe) begin
            pipe_q    <= '0;
            drop_done <= 1'b0;
        end else begin
            if (bus.buf_en) pipe_q <= {pipe_q[PD-2:0], ~bus.buf_flush};
            if (real_out && drop_req) drop_done <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m_phase  = P_IDLE;
    int m_k      = 0;
    int m_f      = 0;
    bit m_err    = 1'b0;
    bit m_dropped = 1'b0;
    int dut_first_en = -1;
    int dut_done_cyc = -1;

    // One clock cycle: drive, compare against the frame-level model, advance the model.
    task automatic cycle(input bit v, input bit r, input bit s, input bit a, input bit st);
        logic [4:0] exp_ctrl, got_ctrl;
        logic [9:0] exp_row, exp_col;
        bit exp_ready, exp_en, exp_fl;
        @(negedge clk);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.start     = s;
        bus.abort     = a;
        stray         = st;
        clear_pipe    = s && !a && (m_phase == P_IDLE);
        #1;
        cyc++;
        exp_ready = 1'b0; exp_en = 1'b0; exp_fl = 1'b0;
        if (!a && m_phase == P_RUN) begin exp_ready = r; exp_en = v & r; end
        if (!a && m_phase == P_FLUSH) begin exp_en = r; exp_fl = r; end
        exp_ctrl = {exp_ready, exp_en, exp_fl, m_phase != P_IDLE, m_phase == P_DONE};
        got_ctrl = {bus.in_ready, bus.buf_en, bus.buf_flush, bus.busy, bus.frame_done};
        n_checks++;
        if (got_ctrl !== exp_ctrl)
            $display("FAIL ctrl cyc %0d {rdy,en,flush,busy,done}: got %b expected %b",
                     cyc, got_ctrl, exp_ctrl);
        else n_pass++;
        n_checks++;
        if (bus.cnt_err !== m_err)
            $display("FAIL cnt_err cyc %0d: got %b expected %b", cyc, bus.cnt_err, m_err);
        else n_pass++;
        if (exp_en) begin
            exp_row = (m_phase == P_RUN) ? 10'(m_k / W) : 10'(H - 1);
            exp_col = (m_phase == P_RUN) ? 10'(m_k % W) : 10'(W - 1);
            n_checks++;
            if (bus.buf_row !== exp_row || bus.buf_col !== exp_col)
                $display("FAIL index cyc %0d: got (%0d,%0d) expected (%0d,%0d)",
                         cyc, bus.buf_row, bus.buf_col, exp_row, exp_col);
            else n_pass++;
        end
        if (bus.buf_en === 1'b1 && dut_first_en < 0) dut_first_en = cyc;
        if (bus.frame_done === 1'b1) dut_done_cyc = cyc;
        if (a && m_phase != P_IDLE) m_phase = P_IDLE;
        else case (m_phase)
            P_IDLE: begin
                if (st) m_err = 1'b1;
                if (s && !a) begin
                    m_phase = P_RUN; m_k = 0; m_f = 0; m_err = 1'b0;
                    dut_first_en = -1; dut_done_cyc = -1;
                end
            end
            P_RUN: if (v && r) begin
                m_k++;
                if (m_k == NPIX) m_phase = P_FLUSH;
            end
            P_FLUSH: if (r) begin
                m_f++;
                if (m_f == PD) m_phase = P_CHECK;
            end
            P_CHECK: begin
                if (m_dropped) m_err = 1'b1;
                m_phase = P_DONE;
            end
            default: begin
                if (st) m_err = 1'b1;
                m_phase = P_IDLE;
            end
        endcase
    endtask

    task automatic run_frame();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != P_IDLE; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.out_ready = 0;
        stray = 0; drop_req = 0; clear_pipe = 1'b1;
        #12;
        n_checks++;
        if ({bus.in_ready, bus.buf_en, bus.buf_flush, bus.busy, bus.frame_done, bus.cnt_err,
             bus.buf_row, bus.buf_col} !== 26'd0)
            $display("FAIL reset_outputs: got en=%b busy=%b row=%0d col=%0d expected all 0",
                     bus.buf_en, bus.busy, bus.buf_row, bus.buf_col);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_speed();
        run_frame();
        n_checks++;
        if (dut_done_cyc - dut_first_en + 1 !== NPIX + PD + 2)
            $display("FAIL latency_full: got %0d expected %0d",
                     dut_done_cyc - dut_first_en + 1, NPIX + PD + 2);
        else n_pass++;
    endtask

    task automatic test_stall();
        int stalled = 0;
        bit r;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != P_IDLE; i++) begin
            r = !(m_k == W + 2 && stalled < 3);
            cycle(1'b1, r, 1'b0, 1'b0, 1'b0);
            if (!r) begin
                stalled++;
                n_checks++;
                if (bus.buf_row !== 10'd1 || bus.buf_col !== 10'd2)
                    $display("FAIL stall_hold: got (%0d,%0d) expected (1,2)",
                             bus.buf_row, bus.buf_col);
                else n_pass++;
            end
        end
        n_checks++;
        if (dut_done_cyc - dut_first_en + 1 !== NPIX + PD + 2 + 3)
            $display("FAIL latency_stall: got %0d expected %0d",
                     dut_done_cyc - dut_first_en + 1, NPIX + PD + 5);
        else n_pass++;
    endtask

    task automatic test_drop();
        drop_req = 1'b1; m_dropped = 1'b1;
        run_frame();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.cnt_err !== 1'b1)
            $display("FAIL drop_sticky: got %b expected 1", bus.cnt_err);
        else n_pass++;
        drop_req = 1'b0; m_dropped = 1'b0;
    endtask

    task automatic test_stray();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.cnt_err !== 1'b1)
            $display("FAIL stray_err: got %b expected 1", bus.cnt_err);
        else n_pass++;
        run_frame();
    endtask

    task automatic test_abort();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_k < W + 1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_done_cyc !== -1)
            $display("FAIL abort_no_done: got done at %0d expected none", dut_done_cyc);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame();
        n_checks++;
        if (dut_done_cyc - dut_first_en + 1 !== NPIX + PD + 2)
            $display("FAIL latency_after_abort: got %0d expected %0d",
                     dut_done_cyc - dut_first_en + 1, NPIX + PD + 2);
        else n_pass++;
    endtask

    task automatic test_start_mid_run();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_k < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != P_IDLE; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_done_cyc - dut_first_en + 1 !== NPIX + PD + 2)
            $display("FAIL latency_mid_start: got %0d expected %0d",
                     dut_done_cyc - dut_first_en + 1, NPIX + PD + 2);
        else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            m_dropped = 1'($urandom_range(0, 1));
            drop_req  = m_dropped;
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 500 && m_phase != P_IDLE; i++)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (m_phase != P_IDLE || dut_done_cyc < 0)
                $display("FAIL random_frame %0d: got done_cyc %0d expected frame end", f,
                         dut_done_cyc);
            else n_pass++;
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drop_req = 1'b0; m_dropped = 1'b0;
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_phase != P_FLUSH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.buf_flush !== 1'b1)
            $display("FAIL flush_before_rst: got %b expected 1", bus.buf_flush);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.buf_en, bus.buf_flush, bus.busy, bus.frame_done, bus.cnt_err,
             bus.buf_row, bus.buf_col} !== 26'd0)
            $display("FAIL async_rst_outputs: got en=%b flush=%b busy=%b row=%0d col=%0d expected all 0",
                     bus.buf_en, bus.buf_flush, bus.busy, bus.buf_row, bus.buf_col);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m_phase = P_IDLE; m_err = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame();
        n_checks++;
        if (dut_done_cyc - dut_first_en + 1 !== NPIX + PD + 2)
            $display("FAIL latency_after_rst: got %0d expected %0d",
                     dut_done_cyc - dut_first_en + 1, NPIX + PD + 2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_speed();
        test_stall();
        test_drop();
        test_stray();
        test_abort();
        test_start_mid_run();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
